// File: rtl/load_unit_if.sv
// Request, response and data-memory signals of the sequential load unit.
// slave = the load unit itself; master = the core/memory side driving it.
interface load_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic [2:0]      req_f3;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_fault;
    logic            mem_req;
    logic            mem_gnt;
    logic [31:0]     mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid;

    // All three channels use valid/ready-style handshakes: a transfer happens on a
    // rising clk edge where both sides are high (req_valid&req_ready,
    // rsp_valid&rsp_ready, mem_req&mem_gnt); the initiator holds its payload stable
    // until then. mem_rvalid is a one-cycle strobe with no back-pressure.
    modport slave (
        input  req_valid, req_addr, req_f3, rsp_ready, mem_gnt, mem_rdata, mem_rvalid,
        output req_ready, rsp_valid, rsp_data, rsp_fault, mem_req, mem_addr
    );

    modport master (
        output req_valid, req_addr, req_f3, rsp_ready, mem_gnt, mem_rdata, mem_rvalid,
        input  req_ready, rsp_valid, rsp_data, rsp_fault, mem_req, mem_addr
    );
endinterface

// File: rtl/load_unit.sv
// Sequential load unit: issues one or two aligned reads per load, merges the beats
// and returns the sign/zero-extended result (or a fault) over a valid/ready response.
module load_unit #(
    parameter int XLEN             = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    load_unit_if.slave bus,
    output logic [2:0] dbg_state_o
);
    localparam int BYTES = XLEN / 8;
    localparam int OFS_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     base_q, base_d;
    logic [OFS_W-1:0] off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            ext_q, ext_d;
    logic            cross_q, cross_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            fault_q, fault_d;

    logic [OFS_W-1:0] req_off;
    logic [3:0]       req_size;
    logic [4:0]       req_end;
    logic             req_cross;
    logic             req_illegal;

    always_comb begin
        req_off     = bus.req_addr[OFS_W-1:0];
        req_size    = 4'd1 << bus.req_f3[1:0];
        req_end     = 5'(req_off) + 5'(req_size);
        req_cross   = req_end > 5'(BYTES);
        req_illegal = (bus.req_f3 == 3'b111) ||
                      ((XLEN == 32) && ((bus.req_f3 == 3'b011) || (bus.req_f3 == 3'b110)));
    end

    // Beat merge: in WAIT_LO the incoming beat is the low word, in WAIT_HI it is the high word.
    logic [XLEN-1:0]   beat_lo, beat_hi, raw, ext_data;
    logic [2*XLEN-1:0] shifted;
    logic              sign_bit;
    int                nbits;

    always_comb begin
        beat_lo  = (state_q == WAIT_LO) ? bus.mem_rdata : lo_q;
        beat_hi  = (state_q == WAIT_HI) ? bus.mem_rdata : '0;
        shifted  = {beat_hi, beat_lo} >> {off_q, 3'b000};
        raw      = shifted[XLEN-1:0];
        nbits    = 8 << size_q;
        case (size_q)
            2'd0:    sign_bit = raw[7];
            2'd1:    sign_bit = raw[15];
            2'd2:    sign_bit = raw[31];
            default: sign_bit = raw[XLEN-1];
        endcase
        ext_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            ext_data[i] = (i < nbits) ? raw[i] : (ext_q & sign_bit);
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        off_d   = off_q;
        size_d  = size_q;
        ext_d   = ext_q;
        cross_d = cross_q;
        lo_d    = lo_q;
        data_d  = data_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    base_d  = {bus.req_addr[31:OFS_W], {OFS_W{1'b0}}};
                    off_d   = req_off;
                    size_d  = bus.req_f3[1:0];
                    ext_d   = ~bus.req_f3[2];
                    cross_d = req_cross;
                    if (req_illegal || (req_cross && !SPLIT_MISALIGNED)) begin
                        state_d = RESP;
                        fault_d = 1'b1;
                        data_d  = '0;
                    end else begin
                        state_d = REQ_LO;
                    end
                end
            end
            REQ_LO:  if (bus.mem_gnt) state_d = WAIT_LO;
            WAIT_LO: begin
                if (bus.mem_rvalid) begin
                    lo_d = bus.mem_rdata;
                    if (cross_q) begin
                        state_d = REQ_HI;
                    end else begin
                        state_d = RESP;
                        data_d  = ext_data;
                        fault_d = 1'b0;
                    end
                end
            end
            REQ_HI:  if (bus.mem_gnt) state_d = WAIT_HI;
            WAIT_HI: begin
                if (bus.mem_rvalid) begin
                    state_d = RESP;
                    data_d  = ext_data;
                    fault_d = 1'b0;
                end
            end
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            off_q   <= '0;
            size_q  <= '0;
            ext_q   <= 1'b0;
            cross_q <= 1'b0;
            lo_q    <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            off_q   <= off_d;
            size_q  <= size_d;
            ext_q   <= ext_d;
            cross_q <= cross_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    // The high beat address wraps naturally in 32-bit arithmetic.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_data  = data_q;
        bus.rsp_fault = fault_q;
        bus.mem_req   = (state_q == REQ_LO) || (state_q == REQ_HI);
        case (state_q)
            REQ_LO:  bus.mem_addr = base_q;
            REQ_HI:  bus.mem_addr = base_q + 32'(BYTES);
            default: bus.mem_addr = '0;
        endcase
    end

    assign dbg_state_o = state_q;
endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Sequential successor to the combinational load-data formatter.
- Accepts one load request (address + f3) and issues one or two aligned memory reads.
- Merges the returned beats, extracts and sign/zero-extends the addressed bytes, and returns the result over a valid/ready handshake.
- Parametrised for 32- or 64-bit data and for split-or-fault handling of misaligned loads. Sits between the core's memory stage and the data-memory port.

Parameters:
- XLEN, 32, data width; legal values 32 or 64. BYTES = XLEN/8, OFS_W = log2(BYTES).
- SPLIT_MISALIGNED, 1. 1 = loads crossing an XLEN boundary use two beats; 0 = such loads return a fault.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address
- req_f3  in  3  funct3: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  XLEN  extended load data
- rsp_fault  out  1  misaligned or illegal load; rsp_data = 0
- mem_req  out  1  memory read request
- mem_gnt  in  1  memory accepted request (same-cycle handshake with mem_req)
- mem_addr  out  32  XLEN-aligned read address
- mem_rdata  in  XLEN  read data
- mem_rvalid  in  1  read data valid, at least 1 cycle after grant

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_fault=0, rsp_data=0, mem_req=0, mem_addr=0.
  - Reset wins over every other input in the same cycle.
  - Reset mid-transaction drops the load; a late mem_rvalid after reset is ignored in IDLE.
- Size from f3[1:0]: 1/2/4/8 bytes. ext = ~f3[2].
- Illegal f3:
  - f3=111 is illegal.
  - f3=011 or 110 with XLEN=32 is illegal.
- Offset and beat count: off = req_addr[OFS_W-1:0]; crosses = (off + size > BYTES).
- Accept: request latched on req_valid & req_ready. req_ready=1 only in IDLE.
- Latched fields: aligned base = req_addr with low OFS_W bits cleared, off, size, ext, fault class.
- FSM states: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP.
  - IDLE -> RESP on accept when the load is illegal, or crosses with SPLIT_MISALIGNED=0. rsp_fault=1, no memory access.
  - IDLE -> REQ_LO otherwise.
  - REQ_LO: mem_req=1, mem_addr=base; held stable until mem_gnt. On grant -> WAIT_LO.
  - WAIT_LO: on mem_rvalid, capture lo beat. -> REQ_HI if crosses, else -> RESP.
  - REQ_HI: mem_req=1, mem_addr=base+BYTES, wrapping modulo 2^32. On grant -> WAIT_HI.
  - WAIT_HI: on mem_rvalid, capture hi beat -> RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_fault are registered and stable until rsp_ready; then -> IDLE.
- Ordering: at most one outstanding memory request. mem_rvalid outside WAIT_* is ignored.
- Data merge (registered on entry to RESP):
  - raw = ({hi,lo} >> off*8), truncated to size bytes; hi = 0 for single-beat loads.
  - If ext: sign-extend from raw bit size*8-1; else zero-extend to XLEN.
- Latency with zero-wait memory (gnt in REQ state, rvalid next cycle):
  - Single-beat: accept to rsp_valid = 3 cycles.
  - Split: accept to rsp_valid = 5 cycles.
  - Fault: accept to rsp_valid = 1 cycle.
- Throughput: no new accept until the response handshake completes; req_ready rises the cycle after it.
- rsp_ready held low: RESP persists indefinitely with no output change.

Test Plan:
- Aligned single-beat load, XLEN=32, mem word 0x8765_43F1:
  - LW at 0x100 -> one mem_req at 0x100, rsp_data 0x8765_43F1, fault 0, valid 3 cycles after accept.
  - LB at 0x100 -> 0xFFFF_FFF1. LBU at 0x100 -> 0x0000_00F1. LH at 0x102 -> 0xFFFF_8765.
- Split load, XLEN=32, SPLIT=1, word 0x200 = 0xAABB_CCDD, word 0x204 = 0x1122_3344:
  - LW at 0x203 -> reads at 0x200 then 0x204, rsp_data 0x2233_44AA.
  - LH at 0x203 -> 0x0000_44AA.
- Fault paths:
  - SPLIT=0, LW at 0x203 -> no mem_req, rsp_fault=1, rsp_data 0 one cycle after accept.
  - f3=111 -> fault. XLEN=32 LD -> fault.
- Wrap and XLEN=64, SPLIT=1: LD at 0xFFFF_FFFC -> reads at 0xFFFF_FFF8 then 0x0000_0000; data merged correctly.
- Backpressure:
  - mem_gnt low 4 cycles: mem_req/mem_addr stable throughout.
  - rsp_ready low 5 cycles: rsp_data stable and req_ready=0 throughout; accept next request after the handshake.
- Reset mid-load: assert rst_n=0 in WAIT_LO, then a late mem_rvalid -> outputs at reset values, no response produced; next LW completes normally.
